zxw_disp_scan_v: RTL

//  Reader side of the CPU display-register interface. Takes the CPU's two 4-bit

---
 rtl/zxw_disp_scan_v.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/zxw_disp_scan_v.sv
// rtl/zxw_disp_scan_v.sv - two-digit multiplexed 7-segment scanner for the CPU display registers
module zxw_disp_scan_v #(
  parameter int PRESCALE   = 50000,
  parameter int GAP        = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] DHR_in,
  input  logic [3:0] DLR_in,
  input  logic       En,
  output logic [6:0] Seg_out,
  output logic [1:0] Dig_out,
  output logic       Frame_tick
);

  localparam int   MAXV    = (PRESCALE > GAP) ? PRESCALE : GAP;
  localparam int   CW      = $clog2(MAXV);
  localparam logic AL      = (ACTIVE_LOW != 0);
  localparam logic BLZ     = (BLANK_LZ != 0);
  localparam logic [6:0] SEG_OFF = {7{AL}};
  localparam logic [1:0] DIG_OFF = {2{AL}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIG_H = 3'd1,
    GAP_H = 3'd2,
    DIG_L = 3'd3,
    GAP_L = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sh_h_q, sh_h_d;
  logic [3:0]    sh_l_q, sh_l_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          tick_q, tick_d;
  logic [6:0]    seg_ah;
  logic [1:0]    dig_ah;

  // Hex to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  // Next state, slot counter, snapshot, and outputs for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sh_h_d  = sh_h_q;
    sh_l_d  = sh_l_q;
    tick_d  = 1'b0;
    seg_ah  = 7'h00;
    dig_ah  = 2'b00;
    if (!En) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DIG_H;
          cnt_d   = '0;
        end
        DIG_H: if (cnt_q == CW'(PRESCALE - 1)) begin
          state_d = GAP_H;
          cnt_d   = '0;
        end
        GAP_H: if (cnt_q == CW'(GAP - 1)) begin
          state_d = DIG_L;
          cnt_d   = '0;
        end
        DIG_L: if (cnt_q == CW'(PRESCALE - 1)) begin
          state_d = GAP_L;
          cnt_d   = '0;
        end
        GAP_L: if (cnt_q == CW'(GAP - 1)) begin
          state_d = DIG_H;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      // Both digits of a frame come from one capture taken at frame start
      if (state_d == DIG_H && state_q != DIG_H) begin
        sh_h_d = DHR_in;
        sh_l_d = DLR_in;
        tick_d = 1'b1;
      end
    end
    case (state_d)
      DIG_H: if (!(BLZ && sh_h_d == 4'd0)) begin
        seg_ah = hex_decode(sh_h_d);
        dig_ah = 2'b10;
      end
      DIG_L: begin
        seg_ah = hex_decode(sh_l_d);
        dig_ah = 2'b01;
      end
      default: begin
        seg_ah = 7'h00;
        dig_ah = 2'b00;
      end
    endcase
    seg_d = seg_ah ^ SEG_OFF;
    dig_d = dig_ah ^ DIG_OFF;
  end

  // State and registered outputs; reset wins over enable
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_h_q  <= 4'd0;
      sh_l_q  <= 4'd0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_h_q  <= sh_h_d;
      sh_l_q  <= sh_l_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign Seg_out    = seg_q;
  assign Dig_out    = dig_q;
  assign Frame_tick = tick_q;

endmodule
